nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder/subtractor built around a single cla_4 slice.
- Sequences operands one nibble per cycle through the slice, least-significant nibble first, keeping the carry in a register between cycles.
- Valid/ready handshake on the input and output sides.
- Sits in the ALU as the area-minimal add/sub path for wide operands; trades latency for a single 4-bit carry-lookahead slice.

---
 rtl/nibble_serial_adder_pkg.sv | 15 +
 rtl/nibble_serial_adder_cla_4.sv | 38 +++
 rtl/nibble_serial_adder.sv | 132 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared state encodings and slice width for the nibble-serial adder
//
// Purpose: constants shared by the nibble-serial adder top and its slice.
// Ports:   none (package).
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_cla_4.sv
// rtl/nibble_serial_adder_cla_4.sv - 4-bit carry-lookahead adder slice
//
// Purpose: purely combinational 4-bit add with lookahead carries.
// Ports:
//   i_a, i_b  4-bit operands
//   i_cin     carry into bit 0
//   o_sum     4-bit sum
//   o_cout    carry out of bit 3
module cla_4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry is expanded from generate/propagate terms so none of them
    // waits on the carry of the bit below.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle add/sub that pushes one nibble per cycle through a single cla_4
//
// Purpose: WIDTH-bit A+B+cin or A-B, least-significant nibble first, carry
//          held in a register between passes; valid/ready on both sides.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         operand handshake
//   in_a, in_b, in_cin, in_sub  operands, carry-in (add only), subtract select
//   out_valid / out_ready       result handshake
//   out_sum, out_cout, out_ovf  result, final carry (0 = borrow on subtract), signed overflow
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_cout;
    logic             r_ovf;

    logic [IDXW+1:0]  w_shamt;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_slice_sum;
    logic             w_slice_cout;
    logic [WIDTH-1:0] w_sum_mask;
    logic [WIDTH-1:0] w_sum_ins;

    // Bit offset of the current nibble; shifts avoid a variable part-select.
    assign w_shamt    = {r_idx, 2'b00};
    assign w_a_nib    = 4'(r_a >> w_shamt);
    assign w_b_nib    = 4'(r_b >> w_shamt);
    assign w_sum_mask = WIDTH'(4'hF) << w_shamt;
    assign w_sum_ins  = WIDTH'(w_slice_sum) << w_shamt;

    cla_4 u_cla_4 (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone is the handshake.
                    if (in_valid) begin
                        r_a        <= in_a;
                        // Subtract is A + ~B + 1: invert B here and force the carry.
                        r_b        <= in_sub ? ~in_b : in_b;
                        r_carry    <= in_sub | in_cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum   <= (r_sum & ~w_sum_mask) | w_sum_ins;
                    r_carry <= w_slice_cout;
                    if (r_idx == LAST_IDX) begin
                        r_idx       <= '0;
                        r_cout      <= w_slice_cout;
                        // Overflow judged against the post-inversion B so it holds for subtract too.
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                       (w_slice_sum[3] != r_a[WIDTH-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder at WIDTH=16
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int LAT = W / 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          in_sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic on unsigned and signed interpretations.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, output logic [W-1:0] s, output logic co,
                         output logic ov);
        int full;
        int sa;
        int sb;
        int r;
        sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
        sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
        if (sub) begin
            full = int'(a) + 65536 - int'(b);
            r    = sa - sb;
        end else begin
            full = int'(a) + int'(b) + int'(cin);
            r    = sa + sb + int'(cin);
        end
        s  = full[W-1:0];
        co = (full >= 65536);
        ov = (r > 32767) || (r < -32768);
    endtask

    // Called at posedge+1 with the block idle; returns one edge after the result handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic early_ready,
                          output logic [W-1:0] s, output logic co, output logic ov,
                          output int lat);
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        in_valid  = 1'b1;
        out_ready = early_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_cin   = 1'($urandom);
        in_sub   = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s  = out_sum;
        co = out_cout;
        ov = out_ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic op_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub, input logic early,
                                input logic [W-1:0] es, input logic ec, input logic eo);
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           lat;
        run_op(a, b, cin, sub, early, s, co, ov, lat);
        chk({tag, " latency"}, lat, LAT);
        chk({tag, " sum"}, s, es);
        chk({tag, " cout"}, co, ec);
        chk({tag, " ovf"}, ov, eo);
        chk({tag, " in_ready after"}, in_ready, 1'b1);
        chk({tag, " out_valid after"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rcin;
        logic         rsub;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        int           lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_sum", out_sum, 16'h0000);
        chk("reset out_cout", out_cout, 1'b0);
        chk("reset out_ovf", out_ovf, 1'b0);
        rst = 1'b0;

        vecs[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, sub: 1'b0, sum: 16'h5555, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sub: 1'b0, sum: 16'h0000, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, sub: 1'b0, sum: 16'h8000, cout: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 16'h0005, b: 16'h0007, cin: 1'b0, sub: 1'b1, sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0};
        vecs[4] = '{a: 16'h8000, b: 16'h0001, cin: 1'b0, sub: 1'b1, sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 16'h0000, b: 16'h0000, cin: 1'b1, sub: 1'b0, sum: 16'h0001, cout: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 16'h1111, b: 16'h1111, cin: 1'b1, sub: 1'b1, sum: 16'h0000, cout: 1'b1, ovf: 1'b0};

        for (int i = 0; i < 7; i++) begin
            op_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                         vecs[i].sub, 1'(i % 2), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end

        for (int i = 0; i < 40; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rcin = 1'($urandom);
            rsub = 1'($urandom);
            if (i % 8 == 0) rb = ~ra;
            model(ra, rb, rcin, rsub, es, ec, eo);
            op_and_check($sformatf("rand%0d", i), ra, rb, rcin, rsub, 1'($urandom), es, ec, eo);
        end

        // Backpressure: result must hold while new operands are offered.
        in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp latency", lat, LAT);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h1111; in_sub = 1'b0; in_cin = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("bp hold out_valid %0d", i), out_valid, 1'b1);
            chk($sformatf("bp hold out_sum %0d", i), out_sum, 16'h5555);
            chk($sformatf("bp hold in_ready %0d", i), in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release in_ready", in_ready, 1'b1);
        chk("bp release out_valid", out_valid, 1'b0);
        chk("bp release out_sum kept", out_sum, 16'h5555);
        repeat (LAT + 2) @(posedge clk);
        #1;
        chk("bp no capture", out_valid, 1'b0);

        // Reset while RUN is on nibble index 2.
        in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst out_valid", out_valid, 1'b0);
        chk("midrst in_ready", in_ready, 1'b1);
        chk("midrst out_sum", out_sum, 16'h0000);
        lat = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) lat++;
        end
        chk("midrst no partial result", lat, 0);
        op_and_check("after rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
